// File: rtl/spi_master_n_pkg.sv
// rtl/spi_master_n_pkg.sv - shared constants and FSM states for the SPI master
package spi_master_n_pkg;

  localparam logic [1:0] RSEL_SPDAT = 2'd0;
  localparam logic [1:0] RSEL_SPCON = 2'd1;
  localparam logic [1:0] RSEL_SPSTA = 2'd2;
  localparam logic [1:0] RSEL_SPDIV = 2'd3;

  localparam int SPCON_SPEN = 0;
  localparam int SPCON_CPOL = 1;
  localparam int SPCON_CPHA = 2;
  localparam int SPCON_LSBF = 3;
  localparam int SPCON_SPIE = 4;
  localparam int SPCON_W    = 5;

  localparam int SPSTA_SPIF = 0;
  localparam int SPSTA_WCOL = 1;
  localparam int SPSTA_BUSY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - bidirectional shift register with parallel load
// ser_o is the bit currently at the outgoing end; serial data enters at the opposite end.
module spi_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic              lsbf_i,
  input  logic              ser_i,
  output logic              ser_o,
  output logic [DATA_W-1:0] par_o
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      sr_d = lsbf_i ? {ser_i, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], ser_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = lsbf_i ? sr_q[0] : sr_q[DATA_W-1];
  assign par_o = sr_q;

endmodule

// File: rtl/spi_master_n.sv
// rtl/spi_master_n.sv - SPI master with SPDAT/SPCON/SPSTA/SPDIV CPU registers
// Mode bits and divider are latched at transfer start; only SPEN can disturb a running transfer.
module spi_master_n
  import spi_master_n_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic [1:0]        RSEL,
  input  logic              WR,
  input  logic              RD,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS_N,
  input  logic              MISO,
  output logic              IRQ
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   spdat_q, spdat_d;
  logic [SPCON_W-1:0]  spcon_q, spcon_d;
  logic [DIV_W-1:0]    spdiv_q, spdiv_d;
  logic                spif_q, spif_d;
  logic                wcol_q, wcol_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ss_n_q, ss_n_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DIV_W-1:0]    div_l_q, div_l_d;
  logic                cpha_l_q, cpha_l_d;
  logic                lsbf_l_q, lsbf_l_d;

  logic                busy, tick, abort;
  logic                wr_dat, wr_con, wr_sta, wr_div, rd_dat;
  logic                set_spif, set_wcol;
  logic                sr_load, sr_shift, sr_out;
  logic [DATA_W-1:0]   sr_par;

  assign busy   = (state_q != ST_IDLE);
  assign tick   = (div_cnt_q == div_l_q);
  assign wr_dat = WR && (RSEL == RSEL_SPDAT);
  assign wr_con = WR && (RSEL == RSEL_SPCON);
  assign wr_sta = WR && (RSEL == RSEL_SPSTA);
  assign wr_div = WR && (RSEL == RSEL_SPDIV);
  assign rd_dat = RD && (RSEL == RSEL_SPDAT);
  assign abort  = busy && wr_con && !DI[SPCON_SPEN];

  spi_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk_i      (CLK),
    .rst_n_i    (RST_N),
    .load_i     (sr_load),
    .load_data_i(DI),
    .shift_i    (sr_shift),
    .lsbf_i     (lsbf_l_q),
    .ser_i      (MISO),
    .ser_o      (sr_out),
    .par_o      (sr_par)
  );

  always_comb begin
    state_d    = state_q;
    spdat_d    = spdat_q;
    spcon_d    = spcon_q;
    spdiv_d    = spdiv_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    div_l_d    = div_l_q;
    cpha_l_d   = cpha_l_q;
    lsbf_l_d   = lsbf_l_q;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    set_spif   = 1'b0;
    set_wcol   = wr_dat && busy;

    if (wr_con) spcon_d = DI[SPCON_W-1:0];
    if (wr_div) spdiv_d = DIV_W'(DI);

    case (state_q)
      ST_IDLE: begin
        sclk_d = spcon_q[SPCON_CPOL];
        mosi_d = 1'b0;
        if (wr_dat) begin
          if (spcon_q[SPCON_SPEN]) begin
            state_d   = ST_LEAD;
            sr_load   = 1'b1;
            ss_n_d    = 1'b0;
            div_cnt_d = '0;
            div_l_d   = spdiv_q;
            cpha_l_d  = spcon_q[SPCON_CPHA];
            lsbf_l_d  = spcon_q[SPCON_LSBF];
            mosi_d    = spcon_q[SPCON_LSBF] ? DI[0] : DI[DATA_W-1];
          end else begin
            spdat_d = DI;
          end
        end
      end
      ST_LEAD: begin
        if (tick) begin
          state_d    = ST_SHIFT;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          div_cnt_d  = '0;
          sclk_d     = !sclk_q;
          edge_cnt_d = edge_cnt_q + 1'b1;
          // edge_cnt_q even means this is an odd (1-based) toggle
          if (edge_cnt_q[0] == cpha_l_q) begin
            sr_shift = 1'b1;
          end else begin
            mosi_d = sr_out;
          end
          if (edge_cnt_q == LAST_EDGE) state_d = ST_TRAIL;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d  = ST_IDLE;
          ss_n_d   = 1'b1;
          mosi_d   = 1'b0;
          set_spif = 1'b1;
          spdat_d  = sr_par;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      ss_n_d   = 1'b1;
      sclk_d   = DI[SPCON_CPOL];
      mosi_d   = 1'b0;
      set_spif = 1'b0;
      spdat_d  = spdat_q;
      sr_shift = 1'b0;
    end
  end

  assign spif_d = set_spif || (spif_q && !(rd_dat || (wr_sta && DI[SPSTA_SPIF])));
  assign wcol_d = set_wcol || (wcol_q && !(wr_sta && DI[SPSTA_WCOL]));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      spdat_q    <= '0;
      spcon_q    <= '0;
      spdiv_q    <= '0;
      spif_q     <= 1'b0;
      wcol_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      div_l_q    <= '0;
      cpha_l_q   <= 1'b0;
      lsbf_l_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      spdat_q    <= spdat_d;
      spcon_q    <= spcon_d;
      spdiv_q    <= spdiv_d;
      spif_q     <= spif_d;
      wcol_q     <= wcol_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      div_l_q    <= div_l_d;
      cpha_l_q   <= cpha_l_d;
      lsbf_l_q   <= lsbf_l_d;
    end
  end

  always_comb begin
    DO = '0;
    case (RSEL)
      RSEL_SPDAT: DO = spdat_q;
      RSEL_SPCON: DO = DATA_W'(spcon_q);
      RSEL_SPSTA: DO = DATA_W'({busy, wcol_q, spif_q});
      RSEL_SPDIV: DO = DATA_W'(spdiv_q);
      default:    DO = '0;
    endcase
  end

  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign SS_N = ss_n_q;
  assign IRQ  = spcon_q[SPCON_SPIE] && spif_q;

endmodule

// File: tb/tb_spi_master_n.sv
// tb/tb_spi_master_n.sv - self-checking bench for spi_master_n (8-bit and 16-bit instances)
module tb_spi_master_n;

  localparam logic [1:0] A_DAT = 2'd0, A_CON = 2'd1, A_STA = 2'd2, A_DIV = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0]  di8, do8;
  logic [1:0]  rsel8;
  logic        wr8, rd8, sclk8, mosi8, ssn8, miso8, irq8, loop8, miso_drv8;
  logic [15:0] di16, do16;
  logic [1:0]  rsel16;
  logic        wr16, rd16, sclk16, mosi16, ssn16, miso16, irq16, loop16, miso_drv16;

  int passed = 0;
  int total  = 0;

  assign miso8  = loop8  ? mosi8  : miso_drv8;
  assign miso16 = loop16 ? mosi16 : miso_drv16;

  spi_master_n #(.DATA_W(8), .DIV_W(8)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .DI(di8), .DO(do8), .RSEL(rsel8), .WR(wr8), .RD(rd8),
    .SCLK(sclk8), .MOSI(mosi8), .SS_N(ssn8), .MISO(miso8), .IRQ(irq8));

  spi_master_n #(.DATA_W(16), .DIV_W(8)) u_dut16 (
    .CLK(clk), .RST_N(rst_n), .DI(di16), .DO(do16), .RSEL(rsel16), .WR(wr16), .RD(rd16),
    .SCLK(sclk16), .MOSI(mosi16), .SS_N(ssn16), .MISO(miso16), .IRQ(irq16));

  always #5 clk = ~clk;

  function automatic logic [31:0] get_do(int u);
    return (u == 0) ? {24'd0, do8} : {16'd0, do16};
  endfunction
  function automatic logic get_sclk(int u); return (u == 0) ? sclk8 : sclk16; endfunction
  function automatic logic get_mosi(int u); return (u == 0) ? mosi8 : mosi16; endfunction
  function automatic logic get_ssn(int u);  return (u == 0) ? ssn8  : ssn16;  endfunction

  // bit k of the result is the k-th bit on the wire
  function automatic logic [31:0] order_bits(logic [31:0] w, int dw, bit lsbf);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < dw; k++) r[k] = lsbf ? w[k] : w[dw-1-k];
    return r;
  endfunction

  task automatic bus_wr(input int u, input logic [1:0] s, input logic [31:0] d);
    if (u == 0) begin rsel8 = s; di8 = d[7:0]; wr8 = 1'b1; end
    else begin rsel16 = s; di16 = d[15:0]; wr16 = 1'b1; end
    @(posedge clk); #1;
    wr8 = 1'b0; wr16 = 1'b0;
  endtask

  task automatic bus_rd(input int u, input logic [1:0] s, output logic [31:0] v);
    if (u == 0) begin rsel8 = s; rd8 = 1'b1; end else begin rsel16 = s; rd16 = 1'b1; end
    #1 v = get_do(u);
    @(posedge clk); #1;
    rd8 = 1'b0; rd16 = 1'b0;
  endtask

  task automatic peek(input int u, input logic [1:0] s, output logic [31:0] v);
    if (u == 0) rsel8 = s; else rsel16 = s;
    #1 v = get_do(u);
  endtask

  task automatic set_miso(input int u, input logic b);
    if (u == 0) miso_drv8 = b; else miso_drv16 = b;
  endtask

  // Acts as the SPI slave: shifts out 'slave' in the configured bit order and records MOSI
  // at every sampling toggle. Returns cycles from the start edge until SPIF is seen.
  task automatic xfer(input int u, input int dw, input logic [31:0] data, input logic [31:0] slave,
                      input bit lp, input bit cpha, input bit lsbf,
                      output int lat, output int tog, output logic [31:0] seq, output bit ssl);
    logic [31:0] sbits, v;
    logic prev;
    int cyc, ns, idx;
    sbits = order_bits(slave, dw, lsbf);
    bus_wr(u, A_STA, 32'h3);
    if (u == 0) loop8 = lp; else loop16 = lp;
    set_miso(u, sbits[0]);
    bus_wr(u, A_DAT, data);
    ssl = (get_ssn(u) == 1'b0);
    prev = get_sclk(u); tog = 0; ns = 0; seq = '0; lat = -1; cyc = 0;
    if (u == 0) rsel8 = A_STA; else rsel16 = A_STA;
    while (cyc < 2000 && lat < 0) begin
      @(posedge clk); #1; cyc++;
      if (get_sclk(u) != prev) begin
        tog++; prev = get_sclk(u);
        if (((tog % 2) == 1) == !cpha) begin
          if (ns < 32) seq[ns] = get_mosi(u);
          ns++;
        end else begin
          idx = cpha ? (tog - 1) / 2 : tog / 2;
          if (idx < dw) set_miso(u, sbits[idx]);
        end
      end
      v = get_do(u);
      if (v[0]) lat = cyc;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b1; wr8 = 0; rd8 = 0; rsel8 = 0; di8 = 0; loop8 = 0; miso_drv8 = 0;
    wr16 = 0; rd16 = 0; rsel16 = 0; di16 = 0; loop16 = 0; miso_drv16 = 0;
    #1 rst_n = 1'b0;
    #1;
    total++; if (ssn8 !== 1'b1) $display("FAIL reset_ss_n got=%0b exp=1", ssn8); else passed++;
    total++; if (sclk8 !== 1'b0) $display("FAIL reset_sclk got=%0b exp=0", sclk8); else passed++;
    total++; if (mosi8 !== 1'b0) $display("FAIL reset_mosi got=%0b exp=0", mosi8); else passed++;
    total++; if (irq8 !== 1'b0) $display("FAIL reset_irq got=%0b exp=0", irq8); else passed++;
    total++; if (ssn16 !== 1'b1) $display("FAIL reset_ss_n16 got=%0b exp=1", ssn16); else passed++;
    for (int s = 0; s < 4; s++) begin
      peek(0, 2'(s), v);
      total++; if (v !== 32'd0) $display("FAIL reset_reg%0d got=%0h exp=0", s, v); else passed++;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    peek(0, A_STA, v);
    total++; if (v !== 32'd0) $display("FAIL reset_release_sta got=%0h exp=0", v); else passed++;
  endtask

  task automatic test_mode0_loopback();
    int lat, tog; logic [31:0] seq, v; bit ssl;
    bus_wr(0, A_DIV, 32'd1);
    bus_wr(0, A_CON, 32'h01);
    xfer(0, 8, 32'hA5, 32'h0, 1'b1, 1'b0, 1'b0, lat, tog, seq, ssl);
    total++; if (!ssl) $display("FAIL m0_ss_n_low got=high exp=low"); else passed++;
    total++; if (tog !== 16) $display("FAIL m0_toggles got=%0d exp=16", tog); else passed++;
    total++; if (lat !== 2 * (2 * 8 + 2)) $display("FAIL m0_latency got=%0d exp=%0d", lat, 2 * 18); else passed++;
    total++; if (seq !== order_bits(32'hA5, 8, 1'b0)) $display("FAIL m0_mosi_seq got=%0h exp=%0h", seq, order_bits(32'hA5, 8, 1'b0)); else passed++;
    bus_rd(0, A_DAT, v);
    total++; if (v !== 32'hA5) $display("FAIL m0_spdat got=%0h exp=a5", v); else passed++;
    peek(0, A_STA, v);
    total++; if (v[0] !== 1'b0) $display("FAIL m0_rd_clears_spif got=%0b exp=0", v[0]); else passed++;
  endtask

  task automatic test_mode3_lsbf();
    int lat, tog; logic [31:0] seq, v; bit ssl;
    bus_wr(0, A_CON, 32'h1F);
    @(posedge clk); #1;
    total++; if (sclk8 !== 1'b1) $display("FAIL m3_sclk_idle got=%0b exp=1", sclk8); else passed++;
    xfer(0, 8, 32'h3C, 32'hFF, 1'b0, 1'b1, 1'b1, lat, tog, seq, ssl);
    total++; if (seq[7:0] !== 8'b0011_1100) $display("FAIL m3_mosi_seq got=%0h exp=3c", seq); else passed++;
    total++; if (lat !== 36) $display("FAIL m3_latency got=%0d exp=36", lat); else passed++;
    total++; if (irq8 !== 1'b1) $display("FAIL m3_irq got=%0b exp=1", irq8); else passed++;
    peek(0, A_DAT, v);
    total++; if (v !== 32'hFF) $display("FAIL m3_spdat got=%0h exp=ff", v); else passed++;
    bus_wr(0, A_STA, 32'h1);
    total++; if (irq8 !== 1'b0) $display("FAIL m3_irq_clear got=%0b exp=0", irq8); else passed++;
  endtask

  task automatic test_wcol();
    logic [31:0] v; int cyc;
    bus_wr(0, A_CON, 32'h01);
    bus_wr(0, A_DIV, 32'd1);
    bus_wr(0, A_STA, 32'h3);
    loop8 = 1'b1;
    bus_wr(0, A_DAT, 32'h5A);
    bus_wr(0, A_DAT, 32'h11);
    peek(0, A_STA, v);
    total++; if (v[2:0] !== 3'b110) $display("FAIL wcol_set got=%0b exp=110", v[2:0]); else passed++;
    cyc = 0;
    while (cyc < 200 && v[0] !== 1'b1) begin @(posedge clk); #1; cyc++; v = get_do(0); end
    total++; if (v[0] !== 1'b1) $display("FAIL wcol_done got=%0b exp=1", v[0]); else passed++;
    peek(0, A_DAT, v);
    total++; if (v !== 32'h5A) $display("FAIL wcol_data got=%0h exp=5a", v); else passed++;
    bus_wr(0, A_STA, 32'h2);
    peek(0, A_STA, v);
    total++; if (v[1:0] !== 2'b01) $display("FAIL wcol_clear got=%0b exp=01", v[1:0]); else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] v; logic prev; int tog, cyc;
    bus_wr(0, A_CON, 32'h00);
    bus_wr(0, A_STA, 32'h3);
    bus_wr(0, A_DAT, 32'h77);
    peek(0, A_STA, v);
    total++; if (v[2] !== 1'b0 || ssn8 !== 1'b1) $display("FAIL spen0_no_start got=busy%0b/ss%0b exp=0/1", v[2], ssn8); else passed++;
    bus_wr(0, A_CON, 32'h03);
    bus_wr(0, A_DIV, 32'd1);
    bus_wr(0, A_DAT, 32'hC3);
    prev = sclk8; tog = 0; cyc = 0;
    while (tog < 5 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (sclk8 != prev) begin tog++; prev = sclk8; end
    end
    total++; if (tog !== 5) $display("FAIL abort_reach5 got=%0d exp=5", tog); else passed++;
    bus_wr(0, A_CON, 32'h02);
    total++; if (ssn8 !== 1'b1) $display("FAIL abort_ss_n got=%0b exp=1", ssn8); else passed++;
    total++; if (sclk8 !== 1'b1) $display("FAIL abort_sclk got=%0b exp=1", sclk8); else passed++;
    total++; if (mosi8 !== 1'b0) $display("FAIL abort_mosi got=%0b exp=0", mosi8); else passed++;
    peek(0, A_STA, v);
    total++; if (v[2:0] !== 3'b000) $display("FAIL abort_sta got=%0b exp=000", v[2:0]); else passed++;
    peek(0, A_DAT, v);
    total++; if (v !== 32'h77) $display("FAIL abort_spdat got=%0h exp=77", v); else passed++;
  endtask

  task automatic test_random();
    int lat, tog, dv; logic [31:0] seq, v, data, slave; bit ssl, cpol, cpha, lsbf;
    for (int i = 0; i < 4; i++) begin
      cpol = 1'($urandom_range(0, 1)); cpha = 1'($urandom_range(0, 1)); lsbf = 1'($urandom_range(0, 1));
      dv = $urandom_range(0, 3);
      data = $urandom & 32'hFF; slave = $urandom & 32'hFF;
      bus_wr(0, A_CON, 32'h1 | (32'(cpol) << 1) | (32'(cpha) << 2) | (32'(lsbf) << 3));
      bus_wr(0, A_DIV, 32'(dv));
      xfer(0, 8, data, slave, 1'b0, cpha, lsbf, lat, tog, seq, ssl);
      total++; if (lat !== (dv + 1) * 18) $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, (dv + 1) * 18); else passed++;
      total++; if (seq !== order_bits(data, 8, lsbf)) $display("FAIL rnd%0d_mosi got=%0h exp=%0h", i, seq, order_bits(data, 8, lsbf)); else passed++;
      peek(0, A_DAT, v);
      total++; if (v !== slave) $display("FAIL rnd%0d_rx got=%0h exp=%0h", i, v, slave); else passed++;
    end
  endtask

  task automatic test_w16();
    int lat, tog; logic [31:0] seq, v; bit ssl;
    bus_wr(1, A_DIV, 32'd0);
    bus_wr(1, A_CON, 32'h01);
    xfer(1, 16, 32'hBEEF, 32'h0, 1'b1, 1'b0, 1'b0, lat, tog, seq, ssl);
    total++; if (lat !== 34) $display("FAIL w16_latency got=%0d exp=34", lat); else passed++;
    total++; if (tog !== 32) $display("FAIL w16_toggles got=%0d exp=32", tog); else passed++;
    peek(1, A_DAT, v);
    total++; if (v !== 32'hBEEF) $display("FAIL w16_spdat got=%0h exp=beef", v); else passed++;
  endtask

  task automatic test_spif_set_wins();
    logic [31:0] v;
    bus_wr(1, A_STA, 32'h3);
    loop16 = 1'b1;
    bus_wr(1, A_DAT, 32'h1234);
    repeat (33) @(posedge clk);
    #1;
    peek(1, A_STA, v);
    total++; if (v[0] !== 1'b0) $display("FAIL setwin_pre got=%0b exp=0", v[0]); else passed++;
    rsel16 = A_DAT; rd16 = 1'b1;
    @(posedge clk); #1;
    rd16 = 1'b0;
    peek(1, A_STA, v);
    total++; if (v[0] !== 1'b1) $display("FAIL setwin_spif got=%0b exp=1", v[0]); else passed++;
    bus_rd(1, A_DAT, v);
    total++; if (v !== 32'h1234) $display("FAIL setwin_spdat got=%0h exp=1234", v); else passed++;
    peek(1, A_STA, v);
    total++; if (v[0] !== 1'b0) $display("FAIL setwin_clear got=%0b exp=0", v[0]); else passed++;
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    bus_wr(0, A_CON, 32'h01);
    bus_wr(0, A_DIV, 32'd2);
    bus_wr(0, A_STA, 32'h3);
    loop8 = 1'b0; miso_drv8 = 1'b1;
    bus_wr(0, A_DAT, 32'h96);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (ssn8 !== 1'b1) $display("FAIL areset_ss_n got=%0b exp=1", ssn8); else passed++;
    total++; if (sclk8 !== 1'b0 || mosi8 !== 1'b0) $display("FAIL areset_bus got=sclk%0b/mosi%0b exp=0/0", sclk8, mosi8); else passed++;
    for (int s = 0; s < 4; s++) begin
      peek(0, 2'(s), v);
      total++; if (v !== 32'd0) $display("FAIL areset_reg%0d got=%0h exp=0", s, v); else passed++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    peek(0, A_STA, v);
    total++; if (v !== 32'd0 || ssn8 !== 1'b1) $display("FAIL areset_no_spif got=sta%0h/ss%0b exp=0/1", v, ssn8); else passed++;
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_lsbf();
    test_wcol();
    test_abort();
    test_random();
    test_w16();
    test_spif_set_wins();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_master_n.md
SPI_MASTER_N -- requirements
Module: spi_master_n

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the transfer and data-bus width (legal range 8..32).
REQ-002 SHALL have parameter DIV_W, default 8, giving the SPDIV register width.
REQ-003 SHALL have port CLK  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port DI  input  DATA_W  CPU write data.
REQ-006 SHALL have port DO  output  DATA_W  CPU read data; a combinational mux of the register selected by RSEL.
REQ-007 SHALL have port RSEL  input  2  register select: 0=SPDAT, 1=SPCON, 2=SPSTA, 3=SPDIV.
REQ-008 SHALL have port WR  input  1  write strobe, one CLK cycle per write.
REQ-009 SHALL have port RD  input  1  read strobe; it drives side effects only.
REQ-010 SHALL have ports SCLK/MOSI/SS_N  output  1 each, and MISO  input  1: the SPI bus.
REQ-011 SHALL have port IRQ  output  1  interrupt, equal to SPIE AND SPIF.

Function
REQ-012 SPCON SHALL hold bits [0] SPEN, [1] CPOL, [2] CPHA, [3] LSBF (LSB first), [4] SPIE; all other bits read 0.
REQ-013 SPSTA SHALL hold bits [0] SPIF, [1] WCOL, [2] BUSY (read-only); all other bits read 0.
REQ-014 Half-period H SHALL be SPDIV+1 CLK cycles; SPDIV=0 gives the fastest SCLK, CLK/2.
REQ-015 The FSM SHALL have states IDLE, LEAD, SHIFT, TRAIL; BUSY=1 in every state except IDLE.
REQ-016 IDLE->LEAD SHALL occur on a WR to SPDAT with SPEN=1 and BUSY=0.
- The write loads the shift register.
- CPOL, CPHA, LSBF and SPDIV are latched at that point.
- SS_N is driven low on the next edge.
REQ-017 A WR to SPDAT with SPEN=0 SHALL update the SPDAT receive/transmit holding value and SHALL NOT start a transfer.
REQ-018 LEAD SHALL last H cycles with SCLK=CPOL, then enter SHIFT.
REQ-019 SHIFT SHALL produce 2*DATA_W SCLK toggles, one every H cycles.
- CPHA=0: MOSI valid from LEAD entry; MISO sampled on odd toggles; MOSI shifted on even toggles.
- CPHA=1: MOSI shifted on odd toggles; MISO sampled on even toggles.
REQ-020 TRAIL SHALL last H cycles with SCLK=CPOL, then enter IDLE.
- On that same edge: SS_N=1, SPIF=1, SPDAT=received word.
- Total latency SHALL be H*(2*DATA_W+2) cycles after the start edge.
REQ-021 LSBF=1 SHALL transmit and receive bit 0 first; LSBF=0 SHALL put the MSB first.
REQ-022 A WR to SPDAT while BUSY=1 SHALL be ignored and SHALL set WCOL.
REQ-023 SPIF SHALL be cleared by RD with RSEL=0, or by WR to SPSTA with DI[0]=1.
REQ-024 WCOL SHALL be cleared by WR to SPSTA with DI[1]=1.
REQ-025 When a set and a clear of SPIF or WCOL hit the same cycle, set SHALL win.
REQ-026 Clearing SPEN while BUSY=1 SHALL abort the transfer on the next edge.
- State goes to IDLE, SS_N=1, SCLK=CPOL.
- SPIF stays unchanged; SPDAT stays unchanged.
REQ-027 In IDLE, SCLK SHALL follow SPCON.CPOL with one cycle latency.
REQ-028 Writes to SPCON/SPDIV while BUSY=1 SHALL update the registers but SHALL NOT affect the transfer in progress (SPEN excepted).
REQ-029 MOSI SHALL be 0 in IDLE.

Reset
REQ-030 RST_N low SHALL asynchronously force the following:
- state=IDLE;
- SPDAT, SPCON, SPSTA, SPDIV and the shift register all 0;
- SCLK=0, MOSI=0, SS_N=1, IRQ=0.
REQ-031 Reset release SHALL take effect synchronously: the first state update is on the first CLK rising edge after RST_N goes high.
REQ-032 Reset mid-transfer SHALL discard the partial word, with no SPIF.

Structure
REQ-033 The shared package SHALL hold:
- the RSEL address constants;
- the SPCON/SPSTA bit-index constants;
- the FSM state enumeration.
REQ-034 The sub-module spi_shift_reg (DATA_W parametrised) SHALL have:
- parallel load;
- serial in/out;
- LSBF direction control;
- parallel out.
REQ-035 The top level SHALL hold the registers, the divider counter, the FSM and the edge counter.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- DATA_W=8, SPDIV=1, mode 0, MSB first, MISO tied to MOSI; write 0xA5 -> SS_N low 1 cycle later; 16 SCLK toggles; SPIF=1 exactly 36 cycles after the write; SPDAT reads 0xA5; that read clears SPIF.
- CPOL=1, CPHA=1, LSBF=1, MISO stuck 1, write 0x3C -> SCLK idles high; MOSI sequence is 0,0,1,1,1,1,0,0; SPDAT=0xFF; IRQ=1 when SPIE=1.
- Second SPDAT write during BUSY with 0x11 -> WCOL=1; the transfer completes with the original data; WR SPSTA 0x02 -> WCOL=0.
- Clear SPEN after 5 SCLK toggles -> next cycle SS_N=1, SCLK=CPOL, BUSY=0, SPIF=0.
- DATA_W=16, SPDIV=0, write 0xBEEF in loopback -> SPIF 34 cycles later; SPDAT=0xBEEF.
- Assert RST_N mid-transfer, asynchronously with no CLK edge -> SS_N=1 and all registers 0 immediately.
